// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the line memory responder: FSM state encoding and
// width helpers used to size the line index and the latency counter.
package line_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_W  = 32;
    localparam int COUNT_W = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of the line index into storage (at least one bit).
    function automatic int index_width(input int num_lines);
        return (clog2(num_lines) < 1) ? 1 : clog2(num_lines);
    endfunction

    // Width of the latency down-counter, able to hold LATENCY.
    function automatic int counter_width(input int latency);
        return (clog2(latency + 1) < 1) ? 1 : clog2(latency + 1);
    endfunction

endpackage

// File: rtl/line_memory_responder_if.sv
// Cache-to-memory line interface. The cache controller is the master and
// issues one request at a time; the memory responder is the slave.
interface line_memory_responder_if #(
    parameter int BLOCK_SIZE = 16
);
    localparam int LINE_W = BLOCK_SIZE * 8;

    logic              is_input_valid;
    logic [31:0]       addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] din;
    logic              is_output_valid;
    logic [LINE_W-1:0] dout;
    logic              mem_ready;
    logic [31:0]       read_count;
    logic [31:0]       write_count;

    modport master (
        output is_input_valid,
        output addr,
        output mem_read,
        output mem_write,
        output din,
        input  is_output_valid,
        input  dout,
        input  mem_ready,
        input  read_count,
        input  write_count
    );

    modport slave (
        input  is_input_valid,
        input  addr,
        input  mem_read,
        input  mem_write,
        input  din,
        output is_output_valid,
        output dout,
        output mem_ready,
        output read_count,
        output write_count
    );

endinterface

// File: rtl/line_memory_responder_line_store.sv
// Single-port line storage: synchronous write, registered read, contents
// zero at power-up. Storage is deliberately not cleared by reset.
module line_store #(
    parameter int NUM_LINES = 1024,
    parameter int LINE_W    = 128,
    parameter int IDX_W     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [NUM_LINES] = '{default: '0};

    // Commit a full line on a write strobe.
    always @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Capture the addressed line into the read register on a read strobe.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/line_memory_responder.sv
// Responder end of the cache-to-memory line interface. Accepts one read or
// write at a time when idle, completes it after LATENCY cycles, and pulses
// is_output_valid for one cycle with the line data on reads.
module line_memory_responder
    import line_memory_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_LINES  = 1024,
    parameter int LATENCY    = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    line_memory_responder_if.slave  bus
);

    localparam int LINE_W = BLOCK_SIZE * 8;
    localparam int IDX_W  = index_width(NUM_LINES);
    localparam int CNT_W  = counter_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    logic               accept;
    logic               commit_write;
    logic               commit_read;
    logic               resp_done;

    logic [IDX_W-1:0]   line_q;
    logic [LINE_W-1:0]  din_q;
    logic               is_write_q;

    logic [COUNT_W-1:0] read_count_q;
    logic [COUNT_W-1:0] write_count_q;

    logic [LINE_W-1:0]  store_rdata;
    logic               store_we;
    logic               store_re;

    // Upper address bits select nothing: lines wrap modulo NUM_LINES.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[ADDR_W-1:IDX_W];

    // Next-state and per-cycle strobes for the request lifecycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        accept       = 1'b0;
        commit_write = 1'b0;
        commit_read  = 1'b0;
        resp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.is_input_valid && (bus.mem_read || bus.mem_write)) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    if (is_write_q) begin
                        commit_write = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        commit_read  = 1'b1;
                        state_next   = RESP;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                resp_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and latency counter; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Latch the request at acceptance; both ops set is treated as a write.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q     <= bus.addr[IDX_W-1:0];
            din_q      <= bus.din;
            is_write_q <= bus.mem_write;
        end
    end

    // Completed-transaction statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            if (commit_write) begin
                write_count_q <= write_count_q + 32'd1;
            end
            if (resp_done) begin
                read_count_q <= read_count_q + 32'd1;
            end
        end
    end

    // A reset on the commit edge suppresses the write and the read capture.
    assign store_we = commit_write & ~reset;
    assign store_re = commit_read & ~reset;

    line_store #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W),
        .IDX_W     (IDX_W)
    ) u_line_store (
        .clk   (clk),
        .we    (store_we),
        .re    (store_re),
        .addr  (line_q),
        .wdata (din_q),
        .rdata (store_rdata)
    );

    assign bus.mem_ready       = (state == IDLE);
    assign bus.is_output_valid = (state == RESP);
    assign bus.dout            = (state == RESP) ? store_rdata : '0;
    assign bus.read_count      = read_count_q;
    assign bus.write_count     = write_count_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder with a transaction-level model
// (line array plus completion timestamps) checked every cycle.
module tb_line_memory_responder;

    localparam int BLOCK_SIZE = 16;
    localparam int NUM_LINES  = 1024;
    localparam int LATENCY    = 4;
    localparam int LINE_W     = BLOCK_SIZE * 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    line_memory_responder_if #(.BLOCK_SIZE(BLOCK_SIZE)) bus ();

    line_memory_responder #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_LINES  (NUM_LINES),
        .LATENCY    (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [LINE_W-1:0] mmem [NUM_LINES] = '{default: '0};
    bit                m_ok = 1'b0;
    bit                m_busy = 1'b0;
    bit                m_resp = 1'b0;
    bit                m_wr = 1'b0;
    int                m_done = 0;
    int                m_a = 0;
    logic [LINE_W-1:0] m_d = '0;
    logic [LINE_W-1:0] m_rdata = '0;
    int                m_rc = 0;
    int                m_wc = 0;

    always @(posedge clk) begin
        bit idle;
        cyc = cyc + 1;
        m_ok = 1'b1;
        if (reset) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_rc = 0;
            m_wc = 0;
        end else begin
            idle = !m_busy && !m_resp;
            if (m_resp) begin
                m_rc = m_rc + 1;
                m_resp = 1'b0;
            end
            if (m_busy && cyc == m_done) begin
                if (m_wr) begin
                    mmem[m_a] = m_d;
                    m_wc = m_wc + 1;
                end else begin
                    m_resp = 1'b1;
                    m_rdata = mmem[m_a];
                end
                m_busy = 1'b0;
            end
            if (idle && bus.is_input_valid && (bus.mem_read || bus.mem_write)) begin
                m_busy = 1'b1;
                m_done = cyc + LATENCY;
                m_wr = bus.mem_write;
                m_a = int'(bus.addr % NUM_LINES);
                m_d = bus.din;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            check("mem_ready", 128'(bus.mem_ready), 128'(!m_busy && !m_resp));
            check("is_output_valid", 128'(bus.is_output_valid), 128'(m_resp));
            check("dout", bus.dout, m_resp ? m_rdata : '0);
            check("read_count", 128'(bus.read_count), 128'(32'(m_rc)));
            check("write_count", 128'(bus.write_count), 128'(32'(m_wc)));
        end
    end

    // Output pulse recorder for the literal expectations.
    int                pulse_count = 0;
    int                last_pulse_cyc = -1;
    logic [LINE_W-1:0] last_pulse_data = '0;

    always @(negedge clk) begin
        if (bus.is_output_valid === 1'b1) begin
            pulse_count = pulse_count + 1;
            last_pulse_cyc = cyc;
            last_pulse_data = bus.dout;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_req();
        bus.is_input_valid = 1'b0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr = '0;
        bus.din = '0;
    endtask

    task automatic wait_ready(output int at_cyc);
        int n;
        n = 0;
        while (bus.mem_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.mem_ready !== 1'b1) begin
            check("ready_timeout", 128'(bus.mem_ready), 128'(1));
        end
        at_cyc = cyc;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LINE_W-1:0] d, output int edge_n);
        int t;
        wait_ready(t);
        bus.is_input_valid = 1'b1;
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.addr = a;
        bus.din = d;
        @(posedge clk);
        #1;
        edge_n = cyc;
        clear_req();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_wr, n_rd, t;
        logic [LINE_W-1:0] d_a5, d_wrap, d_both, d_hold, d_ff;
        d_a5   = {16{8'hA5}};
        d_wrap = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d_both = {4{32'hC0DE_0BAD}};
        d_hold = {8{16'h5A3C}};
        d_ff   = {16{8'hFF}};
        clear_req();

        // Reset, then idle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_ready", 128'(bus.mem_ready), 128'(1));
        check("reset_valid", 128'(bus.is_output_valid), 128'(0));
        check("reset_dout", bus.dout, 128'(0));
        check("reset_rc", 128'(bus.read_count), 128'(0));
        check("reset_wc", 128'(bus.write_count), 128'(0));

        // Write then read line 0x12: ready back at cycle N+5, pulse at N+10.
        issue(1'b0, 1'b1, 32'h12, d_a5, n_wr);
        wait_ready(t);
        check("wr_ready_return", 128'(t - n_wr), 128'(LATENCY));
        issue(1'b1, 1'b0, 32'h12, '0, n_rd);
        wait_ready(t);
        check("rd_pulse_time", 128'(last_pulse_cyc - n_wr), 128'(9));
        check("rd_pulse_data", last_pulse_data, d_a5);
        check("rd_pulse_count", 128'(pulse_count), 128'(1));
        check("rd_ready_return", 128'(t - n_rd), 128'(LATENCY + 1));
        check("after_rw_wc", 128'(bus.write_count), 128'(1));
        check("after_rw_rc", 128'(bus.read_count), 128'(1));

        // Address wrap: 0x405 and 0x005 are the same line.
        issue(1'b0, 1'b1, 32'h405, d_wrap, n_wr);
        issue(1'b1, 1'b0, 32'h005, '0, n_rd);
        wait_ready(t);
        check("wrap_data", last_pulse_data, d_wrap);

        // Both ops set behaves as a write with no response.
        issue(1'b1, 1'b1, 32'h20, d_both, n_wr);
        wait_ready(t);
        check("both_wc", 128'(bus.write_count), 128'(3));
        check("both_no_pulse", 128'(pulse_count), 128'(2));
        issue(1'b1, 1'b0, 32'h20, '0, n_rd);
        wait_ready(t);
        check("both_data", last_pulse_data, d_both);

        // Valid with no op set is ignored.
        @(negedge clk);
        bus.is_input_valid = 1'b1;
        bus.addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noop_ready", 128'(bus.mem_ready), 128'(1));
        end
        clear_req();
        check("noop_wc", 128'(bus.write_count), 128'(3));
        check("noop_rc", 128'(bus.read_count), 128'(3));

        // Read held valid during a write's BUSY: accepted only once ready.
        issue(1'b0, 1'b1, 32'h40, d_hold, n_wr);
        bus.is_input_valid = 1'b1;
        bus.mem_read = 1'b1;
        bus.addr = 32'h40;
        wait_ready(t);
        @(posedge clk);
        #1;
        clear_req();
        wait_ready(t);
        check("hold_pulse_time", 128'(last_pulse_cyc - n_wr), 128'(2 * LATENCY + 1));
        check("hold_data", last_pulse_data, d_hold);
        check("hold_pulse_count", 128'(pulse_count), 128'(4));
        check("hold_wc", 128'(bus.write_count), 128'(4));
        check("hold_rc", 128'(bus.read_count), 128'(4));

        // Reset two cycles into a write; a request during reset is dropped.
        issue(1'b0, 1'b1, 32'h33, d_ff, n_wr);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.is_input_valid = 1'b1;
        bus.mem_write = 1'b1;
        bus.addr = 32'h34;
        bus.din = d_ff;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_req();
        check("rst_ready", 128'(bus.mem_ready), 128'(1));
        check("rst_wc", 128'(bus.write_count), 128'(0));
        check("rst_rc", 128'(bus.read_count), 128'(0));
        repeat (LATENCY + 2) @(negedge clk);
        check("rst_no_commit_wc", 128'(bus.write_count), 128'(0));
        issue(1'b1, 1'b0, 32'h33, '0, n_rd);
        wait_ready(t);
        check("rst_abandoned_write", last_pulse_data, 128'(0));
        issue(1'b1, 1'b0, 32'h34, '0, n_rd);
        wait_ready(t);
        check("rst_dropped_request", last_pulse_data, 128'(0));
        check("rst_final_rc", 128'(bus.read_count), 128'(2));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_memory_responder.md
# line_memory_responder

Responder end of the cache-to-memory line interface. Holds line-granular backing storage and serves one outstanding read or write per transaction after a fixed latency. Uses a mem_ready / is_output_valid handshake. The cache controller is the initiator; this block sits directly below it and replaces the behavioural data memory in cache-level benches.

## Interface
- BLOCK_SIZE, 16: line size in bytes; the data ports are BLOCK_SIZE*8 bits wide.
- NUM_LINES, 1024: storage depth in lines; must be a power of two.
- LATENCY, 50: cycles from request acceptance to completion; must be ≥ 1.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- is_input_valid  in  1  request present this cycle.
- addr  in  32  line address (byte address already shifted right by CLOG2(BLOCK_SIZE)).
- mem_read  in  1  request is a line read.
- mem_write  in  1  request is a line write.
- din  in  BLOCK_SIZE*8  write line data.
- is_output_valid  out  1  one-cycle pulse; dout holds read data.
- dout  out  BLOCK_SIZE*8  read line data; 0 when is_output_valid=0.
- mem_ready  out  1  block can accept a request this cycle.
- read_count  out  32  completed reads since reset.
- write_count  out  32  completed writes since reset.

## Operation
- States: IDLE, BUSY, RESP.
- Request acceptance:
  - A request is accepted at a clk edge where state=IDLE, is_input_valid=1, and mem_read|mem_write=1.
  - On acceptance, addr[CLOG2(NUM_LINES)-1:0], din and the op are latched. Upper address bits are ignored, so addresses wrap modulo NUM_LINES.
  - If mem_read=mem_write=1, the request is treated as a write and produces no read response.
  - If is_input_valid=1 with neither op set, the request is ignored and the block stays IDLE.
- IDLE→BUSY on accept; the latency counter is loaded with LATENCY-1.
- BUSY:
  - The counter decrements each cycle; inputs are ignored.
  - At counter=0:
    - write: the line is committed to storage on that edge, write_count+1, next state IDLE.
    - read: storage is read into the dout register, next state RESP.
- RESP: is_output_valid=1 and dout valid for exactly one cycle, read_count+1 on the exit edge, then IDLE.
- mem_ready=1 only in IDLE. Requests presented while mem_ready=0 are not accepted and are not queued.
- Read-after-write to the same line returns the new data, because a write commits before mem_ready returns.
- Counters wrap at 2^32.
- Storage contents are zero at time 0. Reset does not clear storage.

## Timing
- Reset values: state=IDLE, mem_ready=1, is_output_valid=0, dout=0, read_count=0, write_count=0, latency counter=0.
- With a request accepted at edge N:
  - mem_ready=0 from cycle N+1.
  - Read: is_output_valid=1 in cycle N+LATENCY+1 (the cycle after edge N+LATENCY); mem_ready=1 again in cycle N+LATENCY+2.
  - Write: storage updated at edge N+LATENCY; mem_ready=1 in cycle N+LATENCY+1; no output pulse.
- LATENCY=1: BUSY lasts one cycle; the timing above still holds.
- Back-to-back: a new request may be accepted in the first cycle mem_ready is 1 again, so each read occupies LATENCY+2 cycles of throughput and each write LATENCY+1.
- Reset mid-operation:
  - The in-flight request is abandoned.
  - A write whose commit edge has not occurred is not committed.
  - A pending response is dropped.
  - Outputs return to their reset values on the reset edge.
- Reset and an accept condition in the same cycle: reset wins and the request is not accepted.

## Structure
- Shared header (with the existing CLOG2 include): state encoding localparams (IDLE, BUSY, RESP) and width helpers (index width = CLOG2(NUM_LINES), counter width = CLOG2(LATENCY+1)).
- One sub-module, line_store: a single-port NUM_LINES × BLOCK_SIZE*8 array with synchronous write and registered read, zero-initialised.
- The FSM, latency counter, request latches and statistics counters stay in the top module.

## Test plan
- Reset, then idle 5 cycles → mem_ready=1, is_output_valid=0, dout=0, both counts 0.
- LATENCY=4: write line 0x12 with din=0xA5…A5 at edge N, then read 0x12 once ready → mem_ready=1 at N+5; output pulse 0xA5…A5 exactly one cycle at N+10; write_count=1, read_count=1.
- Address wrap: write addr 0x405 (NUM_LINES=1024), read addr 0x005 → returns the written data.
- Request with both mem_read=1 and mem_write=1 → storage written, no is_output_valid pulse, write_count+1. Request with neither op set → no state change.
- New request held valid during BUSY → ignored; only accepted once mem_ready=1, verified by count increments.
- Reset asserted two cycles into a write of 0xFF…FF to a line holding 0 → later read returns 0; counts are 0 after reset.
